// File: rtl/micro_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : micro_pkg                                                  |
// | Description : Shared opcodes, FSM state type and instruction field       |
// |               positions for param_micro_core.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package micro_pkg;

    // 2-bit opcodes carried in ir[7:6]
    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_STORE  = 2'b10;
    localparam logic [1:0] OP_BRANCH = 2'b11;

    // Two-state fetch/execute sequencer
    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    // Instruction field bit positions
    localparam int IR_OP_HI = 7;
    localparam int IR_OP_LO = 6;
    localparam int IR_RS_HI = 5;
    localparam int IR_RS_LO = 4;
    localparam int IR_RT_HI = 3;
    localparam int IR_RT_LO = 2;
    localparam int IR_RD_HI = 1;
    localparam int IR_RD_LO = 0;

endpackage : micro_pkg
`default_nettype wire

// File: rtl/micro_dmem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : micro_dmem                                                 |
// | Description : DEPTH x DATA_W data memory, asynchronous read, synchronous |
// |               write. Reset loads M[i]=i in the lower half and            |
// |               M[i]=-(i-DEPTH/2) in the upper half.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module micro_dmem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Reset restores the fixed initial pattern; otherwise commit stores
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i < DEPTH / 2) begin
                    mem_q[i] <= DATA_W'(i);
                end else begin
                    mem_q[i] <= DATA_W'(-(i - DEPTH / 2));
                end
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Combinational read so a LOAD sees the pre-edge contents
    assign rdata_o = mem_q[addr_i];

endmodule : micro_dmem
`default_nettype wire

// File: rtl/param_micro_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : param_micro_core                                           |
// | Description : Parametrised 4-register, 8-bit-ISA micro core with a       |
// |               FETCH/EXEC sequencer, instruction-fetch handshake, step    |
// |               enable and retired-instruction counter.                    |
// |               Optional macro MICRO_BRANCH_COND_EN turns op 11 into BEQ.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module param_micro_core
    import micro_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DMEM_DEPTH = 32,
    parameter int PC_W       = 8,
    parameter int RETIRE_W   = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                step,
    input  logic [7:0]          instruction,
    input  logic                instr_valid,
    output logic                instr_req,
    output logic [PC_W-1:0]     instruction_address,
    output logic [1:0]          op,
    output logic                mem_write,
    output logic                mem_read,
    output logic                reg_write,
    output logic [DATA_W-1:0]   wb_data,
    output logic [RETIRE_W-1:0] retire_count
);

    localparam int AW = $clog2(DMEM_DEPTH);

    state_t                state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [7:0]            ir_q, ir_d;
    logic [DATA_W-1:0]     gpr_q [4];
    logic [DATA_W-1:0]     wb_q;
    logic [RETIRE_W-1:0]   retire_q;

    logic                  w_commit;
    logic [1:0]            w_op, w_rs, w_rt, w_rd;
    logic [1:0]            w_imm2;
    logic [DATA_W-1:0]     w_rs_val, w_rt_val;
    logic [DATA_W-1:0]     w_imm_data;
    logic [PC_W-1:0]       w_imm_pc;
    logic [DATA_W-1:0]     w_addr_sum;
    logic [DATA_W-1:0]     w_add_sum;
    logic [AW-1:0]         w_addr;
    logic [DATA_W-1:0]     w_mem_rdata;
    logic                  w_taken;
    logic [1:0]            w_rf_addr;
    logic [DATA_W-1:0]     w_rf_data;

    // Instruction field decode of the latched instruction
    assign w_op   = ir_q[IR_OP_HI:IR_OP_LO];
    assign w_rs   = ir_q[IR_RS_HI:IR_RS_LO];
    assign w_rt   = ir_q[IR_RT_HI:IR_RT_LO];
    assign w_rd   = ir_q[IR_RD_HI:IR_RD_LO];
    assign w_imm2 = ir_q[IR_RD_HI:IR_RD_LO];

    assign w_rs_val   = gpr_q[w_rs];
    assign w_rt_val   = gpr_q[w_rt];
    assign w_imm_data = DATA_W'($signed(w_imm2));
    assign w_imm_pc   = PC_W'($signed(w_imm2));
    assign w_addr_sum = w_rs_val + w_imm_data;
    assign w_add_sum  = w_rs_val + w_rt_val;

    // Memory address is the low AW bits of base+imm, zero-extended if the
    // data path is narrower than the address
    generate
        if (AW <= DATA_W) begin : g_addr_slice
            logic w_addr_hi_unused;
            assign w_addr           = w_addr_sum[AW-1:0];
            assign w_addr_hi_unused = ^w_addr_sum;
        end else begin : g_addr_extend
            assign w_addr = {{(AW - DATA_W){1'b0}}, w_addr_sum};
        end
    endgenerate

`ifdef MICRO_BRANCH_COND_EN
    assign w_taken = (w_rs_val == w_rt_val);
`else
    assign w_taken = 1'b1;
`endif

    // Sequencer: fetch handshake, then wait for step to commit
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        instr_req = 1'b0;
        w_commit  = 1'b0;
        case (state_q)
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    ir_d    = instruction;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (step) begin
                    w_commit = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Commit strobes and next-PC selection
    always_comb begin
        mem_write = w_commit && (w_op == OP_STORE);
        mem_read  = w_commit && (w_op == OP_LOAD);
        reg_write = w_commit && (w_op[1] == 1'b0);
        w_rf_addr = (w_op == OP_ADD) ? w_rd : w_rt;
        w_rf_data = (w_op == OP_ADD) ? w_add_sum : w_mem_rdata;
        pc_d      = pc_q;
        if (w_commit) begin
            if ((w_op == OP_BRANCH) && w_taken) begin
                pc_d = pc_q + PC_W'(1) + w_imm_pc;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    // Sequencer state, PC, instruction register and retire counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            retire_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            if (w_commit) begin
                retire_q <= retire_q + RETIRE_W'(1);
            end
        end
    end

    // Register file and console write-back value
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                gpr_q[i] <= '0;
            end
            wb_q <= '0;
        end else if (reg_write) begin
            gpr_q[w_rf_addr] <= w_rf_data;
            wb_q             <= w_rf_data;
        end
    end

    micro_dmem #(
        .DATA_W (DATA_W),
        .DEPTH  (DMEM_DEPTH),
        .AW     (AW)
    ) u_dmem (
        .clock   (clock),
        .reset   (reset),
        .we_i    (mem_write),
        .addr_i  (w_addr),
        .wdata_i (w_rt_val),
        .rdata_o (w_mem_rdata)
    );

    assign instruction_address = pc_q;
    assign op                  = w_op;
    assign wb_data             = wb_q;
    assign retire_count        = retire_q;

endmodule : param_micro_core
`default_nettype wire

// File: tb/tb_param_micro_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_param_micro_core                                        |
// | Description : Scoreboard bench for param_micro_core with directed        |
// |               instruction vectors and hand-computed results.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_param_micro_core;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  instruction = 8'h00;
    logic        instr_valid = 1'b0;
    logic        instr_req;
    logic [7:0]  instruction_address;
    logic [1:0]  op;
    logic        mem_write, mem_read, reg_write;
    logic [7:0]  wb_data;
    logic [15:0] retire_count;

`ifdef MICRO_BRANCH_COND_EN
    localparam logic [7:0] C_PC_AFTER_C6 = 8'd5;
`else
    localparam logic [7:0] C_PC_AFTER_C6 = 8'd3;
`endif

    param_micro_core #(
        .DATA_W(8), .DMEM_DEPTH(32), .PC_W(8), .RETIRE_W(16)
    ) u_dut (
        .clock               (clock),
        .reset               (reset),
        .step                (step),
        .instruction         (instruction),
        .instr_valid         (instr_valid),
        .instr_req           (instr_req),
        .instruction_address (instruction_address),
        .op                  (op),
        .mem_write           (mem_write),
        .mem_read            (mem_read),
        .reg_write           (reg_write),
        .wb_data             (wb_data),
        .retire_count        (retire_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic        mr, mw, rw;
        logic [7:0]  pc, wb;
        logic [15:0] ret;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each commit cycle pops one expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && !instr_req && step) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_commit", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("op", {30'd0, op}, {30'd0, e.op});
                    chk("mem_read", {31'd0, mem_read}, {31'd0, e.mr});
                    chk("mem_write", {31'd0, mem_write}, {31'd0, e.mw});
                    chk("reg_write", {31'd0, reg_write}, {31'd0, e.rw});
                    @(posedge clock);
                    #2;
                    chk("pc", {24'd0, instruction_address}, {24'd0, e.pc});
                    chk("wb_data", {24'd0, wb_data}, {24'd0, e.wb});
                    chk("retire_count", {16'd0, retire_count}, {16'd0, e.ret});
                end
            end
        end
    end

    // Fetch one instruction, optionally hold in EXEC, then step it
    task automatic issue(input logic [7:0] ins, input logic [7:0] pc_exp,
                         input logic [7:0] wb_exp, input logic [15:0] ret_exp,
                         input int hold);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clock);
        while (!instr_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!instr_req) begin
            chk("fetch_timeout", 32'd0, 32'd1);
            return;
        end
        e.op  = ins[7:6];
        e.mr  = (ins[7:6] == 2'b01);
        e.mw  = (ins[7:6] == 2'b10);
        e.rw  = (ins[7] == 1'b0);
        e.pc  = pc_exp;
        e.wb  = wb_exp;
        e.ret = ret_exp;
        sb_q.push_back(e);
        instruction = ins;
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk("hold_strobes", {29'd0, mem_write, mem_read, reg_write}, 32'd0);
            chk("hold_retire", {16'd0, retire_count}, {16'd0, ret_exp - 16'd1});
        end
        @(posedge clock);
        #1;
        step = 1'b1;
        @(posedge clock);
        #1;
        step = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pc_hold;
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_instr_req", {31'd0, instr_req}, 32'd1);
        chk("rst_addr", {24'd0, instruction_address}, 32'd0);
        chk("rst_wb", {24'd0, wb_data}, 32'd0);
        chk("rst_retire", {16'd0, retire_count}, 32'd0);
        chk("rst_m17", {24'd0, u_dut.u_dmem.mem_q[17]}, 32'hFF);
        chk("rst_m31", {24'd0, u_dut.u_dmem.mem_q[31]}, 32'hF1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rel_instr_req", {31'd0, instr_req}, 32'd1);
        chk("rel_addr", {24'd0, instruction_address}, 32'd0);

        // Program: load, add, store with wrap, load back, add
        issue(8'h45, 8'd1, 8'h01, 16'd1, 0);
        issue(8'h16, 8'd2, 8'h02, 16'd2, 0);
        issue(8'h8B, 8'd3, 8'h02, 16'd3, 0);
        chk("m31_after_store", {24'd0, u_dut.u_dmem.mem_q[31]}, 32'h02);
        issue(8'h4F, 8'd4, 8'h02, 16'd4, 0);
        issue(8'h36, 8'd5, 8'h03, 16'd5, 0);

        // Branch back, then halt idiom spinning on pc 4
        issue(8'hC2, 8'd4, 8'h03, 16'd6, 0);
        issue(8'hC3, 8'd4, 8'h03, 16'd7, 0);
        issue(8'hC3, 8'd4, 8'h03, 16'd8, 0);
        issue(8'hC3, 8'd4, 8'h03, 16'd9, 0);
        issue(8'hC6, C_PC_AFTER_C6, 8'h03, 16'd10, 0);

        // No valid instruction: step must be ignored in FETCH
        @(negedge clock);
        pc_hold = C_PC_AFTER_C6;
        step = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("stall_req", {31'd0, instr_req}, 32'd1);
            chk("stall_strobes", {29'd0, mem_write, mem_read, reg_write}, 32'd0);
            chk("stall_pc", {24'd0, instruction_address}, {24'd0, pc_hold});
        end
        step = 1'b0;

        // EXEC held five cycles without step: r2 = 3 + 2
        issue(8'h2E, C_PC_AFTER_C6 + 8'd1, 8'h05, 16'd11, 5);

        // Reset during EXEC of a store discards it
        @(negedge clock);
        instruction = 8'h8B;
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        @(negedge clock);
        chk("abort_no_mw", {31'd0, mem_write}, 32'd0);
        chk("abort_m31_pre", {24'd0, u_dut.u_dmem.mem_q[31]}, 32'h02);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_mw_in_rst", {31'd0, mem_write}, 32'd0);
        chk("abort_m31", {24'd0, u_dut.u_dmem.mem_q[31]}, 32'hF1);
        chk("abort_m1", {24'd0, u_dut.u_dmem.mem_q[1]}, 32'h01);
        chk("abort_pc", {24'd0, instruction_address}, 32'd0);
        chk("abort_retire", {16'd0, retire_count}, 32'd0);
        chk("abort_wb", {24'd0, wb_data}, 32'd0);
        chk("abort_r1", {24'd0, u_dut.gpr_q[1]}, 32'd0);
        chk("abort_r2", {24'd0, u_dut.gpr_q[2]}, 32'd0);
        chk("abort_r3", {24'd0, u_dut.gpr_q[3]}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rerel_req", {31'd0, instr_req}, 32'd1);
        chk("rerel_addr", {24'd0, instruction_address}, 32'd0);

        // First instruction after re-release
        issue(8'h45, 8'd1, 8'h01, 16'd1, 0);

        repeat (3) @(posedge clock);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_param_micro_core
`default_nettype wire

// File: doc/param_micro_core.md
Name: param_micro_core

Overview:
Parametrised successor to the team's 2-bit-opcode, 4-register teaching core.
- Same 8-bit ISA: add, load, store, branch.
- Data width, data-memory depth and PC width are configurable.
- The internal 1 Hz divider is replaced by an external `step` enable.
- Adds an explicit FETCH/EXEC state machine, an instruction-fetch handshake and a retired-instruction counter.
- Sits between the board instruction source (switches or ROM) and the 7-segment console, which shows `wb_data`.

Parameters:
DATA_W, 8, register/memory/ALU data width (≥4)
DMEM_DEPTH, 32, data-memory words; power of 2, ≥4
PC_W, 8, program-counter / instruction-address width
RETIRE_W, 16, retired-instruction counter width

Ports:
clock  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
step  in  1  single-cycle advance enable for EXEC (from divider/button)
instruction  in  8  instruction word; valid when instr_valid=1
instr_valid  in  1  instruction source has valid data
instr_req  out  1  core requests the instruction at instruction_address
instruction_address  out  PC_W  current PC
op  out  2  ir[7:6] of the latched instruction
mem_write  out  1  store commit strobe
mem_read  out  1  load commit strobe
reg_write  out  1  register-file commit strobe
wb_data  out  DATA_W  last value written to the register file (console source)
retire_count  out  RETIRE_W  instructions retired, wrapping

Behaviour:
- Instruction encoding: op=ir[7:6], rs=ir[5:4], rt=ir[3:2], rd=ir[1:0], imm=sign-extend(ir[1:0]) to DATA_W (range -2..+1). Four GPRs, all writable; no hardwired zero.
- op 00 ADD: R[rd] <= R[rs]+R[rt], modulo 2^DATA_W.
- op 01 LOAD: R[rt] <= M[addr].
- op 10 STORE: M[addr] <= R[rt].
- op 11 BRANCH: pc <= pc+1+imm, sign-extended to PC_W, modulo 2^PC_W. Unconditional unless MICRO_BRANCH_COND_EN is defined.
- Address: addr = low log2(DMEM_DEPTH) bits of (R[rs]+imm). Wraps, never out of range.
- Non-branch instructions: pc <= pc+1, wrapping.
- FSM states are FETCH and EXEC.
  - FETCH: instr_req=1. On a rising edge with instr_valid=1: ir<=instruction, go to EXEC. Otherwise stay; `step` is ignored.
  - EXEC: instr_req=0 and instr_valid is ignored. On an edge with step=1, in the same edge: commit the register/memory write, update pc, increment retire_count, go to FETCH. With step=0, stay.
- Strobes are combinational: mem_write=(op==10), mem_read=(op==01), reg_write=(op[1]==0), each ANDed with (state==EXEC && step). They are 1-cycle pulses per step.
- wb_data updates at the same edge as any register write.
- Minimum throughput is 2 cycles per instruction (FETCH with valid, then EXEC with step).
- Reset (reset=0, asynchronous) forces:
  - state=FETCH, pc=0, ir=0, all GPRs=0, wb_data=0, retire_count=0;
  - M[i]=i for i<DMEM_DEPTH/2, M[i]=-(i-DMEM_DEPTH/2) two's complement otherwise.
- Reset mid-EXEC discards the pending instruction; no commit occurs.
- Release is synchronous to clock; the first request is in the cycle after release.
- LOAD reads the pre-edge memory value; no forwarding is needed because single-issue.
- Branch imm=-1 (0xC3) spins on the same pc; this is a legal halt idiom.
- retire_count wraps from all-ones to 0.

Optional Feature:
MICRO_BRANCH_COND_EN
- Defined: op 11 is BEQ. Taken (pc+1+imm) only if R[rs]==R[rt]; otherwise pc+1.
- Undefined: branch is always taken.
- retire_count increments either way.

Decomposition:
- Package micro_pkg holds:
  - opcode constants OP_ADD/OP_LOAD/OP_STORE/OP_BRANCH;
  - FSM state typedef (S_FETCH, S_EXEC);
  - instruction field bit positions.
- One natural sub-module, micro_dmem: DMEM_DEPTH×DATA_W memory with async read, sync write and async-reset initialisation pattern.

Test Plan:
- Defaults used throughout (DATA_W=8, DMEM_DEPTH=32, PC_W=8).
- Reset then release -> instruction_address=0, instr_req=1, wb_data=0, retire_count=0, M[17]=0xFF.
- 0x45 (LOAD r1=M[r0+1]) with valid, then step -> mem_read and reg_write pulse once, wb_data=0x01, pc=1, retire_count=1.
- 0x16 (ADD r2=r1+r1) -> wb_data=0x02. Then 0x8B (STORE M[r0-1]) -> mem_write, M[31]=0x02 (address wrap). Then 0x4F (LOAD r3=M[31]) -> wb_data=0x02.
- At pc=5, 0xC2 -> pc=4. Then 0xC3 -> pc stays 4 across 3 steps while retire_count increments. With MICRO_BRANCH_COND_EN and R[0]≠R[1], 0xC6 -> pc+1.
- instr_valid=0 for 10 cycles with step=1 -> remains in FETCH, no strobes, pc unchanged. In EXEC, step=0 for 5 cycles -> no commit.
- reset low mid-EXEC of a STORE -> memory holds the init pattern, pc=0, GPRs=0, retire_count=0, no mem_write pulse.
